// File: rtl/sif_regfile.sv
// Dual-agent register file: external port (read/write) plus an internal write agent
// whose writes are deferred one-deep while the external port is writing. Optional parity: SIF_PARITY_EN.
module sif_regfile #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] xa_addr,
  input  logic [DATA_W-1:0] xa_data_wr,
  input  logic              xa_wr_s,
  input  logic              xa_rd_s,
  output logic [DATA_W-1:0] xa_data_rd,
  output logic              xa_rd_valid,
  output logic              xa_err,
  input  logic [ADDR_W-1:0] wa_addr,
  input  logic [DATA_W-1:0] wa_data_wr,
  input  logic              wa_wr_s,
  output logic              wa_busy,
  output logic              wa_drop
`ifdef SIF_PARITY_EN
  ,
  input  logic              xa_par_inj,
  output logic              xa_par_err
`endif
);

  localparam int AI = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef SIF_PARITY_EN
  localparam int WW = DATA_W + 1;
`else
  localparam int WW = DATA_W;
`endif

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [WW-1:0]     mem_q [DEPTH];
  logic [0:0]        state_q, state_d;
  logic [AI-1:0]     pend_addr_q, pend_addr_d;
  logic [DATA_W-1:0] pend_data_q, pend_data_d;
  logic [DATA_W-1:0] xa_data_rd_q, xa_data_rd_d;
  logic              xa_rd_valid_q, xa_err_q, wa_drop_q, wa_drop_d;

  logic              xa_in, wa_in, fwd;
  logic [AI-1:0]     xa_idx, wa_idx, wr_idx;
  logic [WW-1:0]     xa_word, wa_word, pend_word, wr_word, rd_word;
  logic              wr_en;

  assign xa_in  = 32'(xa_addr) < DEPTH;
  assign wa_in  = 32'(wa_addr) < DEPTH;
  assign xa_idx = xa_addr[AI-1:0];
  assign wa_idx = wa_addr[AI-1:0];

  // Even parity: the stored bit makes the XOR of the whole word zero.
`ifdef SIF_PARITY_EN
  assign xa_word   = {(^xa_data_wr) ^ xa_par_inj, xa_data_wr};
  assign wa_word   = {^wa_data_wr, wa_data_wr};
  assign pend_word = {^pend_data_q, pend_data_q};
`else
  assign xa_word   = xa_data_wr;
  assign wa_word   = wa_data_wr;
  assign pend_word = pend_data_q;
`endif

  assign rd_word = mem_q[xa_idx];
  assign fwd     = (state_q == HOLD) && (xa_idx == pend_addr_q);

  always_comb begin
    xa_data_rd_d = xa_data_rd_q;
    if (xa_rd_s)
      xa_data_rd_d = !xa_in ? '0 : (fwd ? pend_data_q : rd_word[DATA_W-1:0]);
  end

  // Single storage write port: a deferred wa write only commits in a cycle without an xa write.
  always_comb begin
    state_d     = state_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    wa_drop_d   = 1'b0;
    wr_en       = xa_wr_s && xa_in;
    wr_idx      = xa_idx;
    wr_word     = xa_word;
    if (state_q == HOLD) begin
      wa_drop_d = wa_wr_s;
      if (!xa_wr_s) begin
        wr_en   = 1'b1;
        wr_idx  = pend_addr_q;
        wr_word = pend_word;
        state_d = IDLE;
      end
    end else if (wa_wr_s) begin
      if (!wa_in) begin
        wa_drop_d = 1'b1;
      end else if (xa_wr_s) begin
        state_d     = HOLD;
        pend_addr_d = wa_idx;
        pend_data_d = wa_data_wr;
      end else begin
        wr_en   = 1'b1;
        wr_idx  = wa_idx;
        wr_word = wa_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      state_q       <= IDLE;
      pend_addr_q   <= '0;
      pend_data_q   <= '0;
      xa_data_rd_q  <= '0;
      xa_rd_valid_q <= 1'b0;
      xa_err_q      <= 1'b0;
      wa_drop_q     <= 1'b0;
    end else begin
      if (wr_en) mem_q[wr_idx] <= wr_word;
      state_q       <= state_d;
      pend_addr_q   <= pend_addr_d;
      pend_data_q   <= pend_data_d;
      xa_data_rd_q  <= xa_data_rd_d;
      xa_rd_valid_q <= xa_rd_s;
      xa_err_q      <= (xa_rd_s || xa_wr_s) && !xa_in;
      wa_drop_q     <= wa_drop_d;
    end
  end

`ifdef SIF_PARITY_EN
  logic xa_par_err_q;
  always_ff @(posedge clk) begin
    if (!rst_n) xa_par_err_q <= 1'b0;
    else        xa_par_err_q <= xa_rd_s && xa_in && !fwd && (^rd_word);
  end
  assign xa_par_err = xa_par_err_q;
`endif

  assign xa_data_rd  = xa_data_rd_q;
  assign xa_rd_valid = xa_rd_valid_q;
  assign xa_err      = xa_err_q;
  assign wa_drop     = wa_drop_q;
  assign wa_busy     = (state_q == HOLD);

endmodule

// File: tb/tb_sif_regfile.sv
// Bench for sif_regfile: directed scenarios plus random traffic against a storage/pending-write model.
module tb_sif_regfile;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] xa_addr = '0, xa_data_wr = '0, wa_addr = '0, wa_data_wr = '0;
  logic        xa_wr_s = 1'b0, xa_rd_s = 1'b0, wa_wr_s = 1'b0;
  logic [15:0] xa_data_rd;
  logic        xa_rd_valid, xa_err, wa_busy, wa_drop;
`ifdef SIF_PARITY_EN
  logic        xa_par_inj = 1'b0;
  logic        xa_par_err;
`endif

  sif_regfile #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .xa_addr(xa_addr), .xa_data_wr(xa_data_wr), .xa_wr_s(xa_wr_s), .xa_rd_s(xa_rd_s),
    .xa_data_rd(xa_data_rd), .xa_rd_valid(xa_rd_valid), .xa_err(xa_err),
    .wa_addr(wa_addr), .wa_data_wr(wa_data_wr), .wa_wr_s(wa_wr_s),
    .wa_busy(wa_busy), .wa_drop(wa_drop)
`ifdef SIF_PARITY_EN
    , .xa_par_inj(xa_par_inj), .xa_par_err(xa_par_err)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  // Reference model: array of words plus an optional deferred write.
  logic [15:0] mem_m [DEPTH];
  bit          pend;
  int          pa;
  logic [15:0] pd;
  logic [15:0] e_rd;
  bit          e_vld, e_err, e_drop, e_busy;

  function automatic void model(input bit r, input bit w, input int xa, input logic [15:0] xd,
                                input bit ww, input int wa, input logic [15:0] wd);
    bit xin = xa < DEPTH;
    bit win = wa < DEPTH;
    e_vld  = r;
    if (r) e_rd = !xin ? 16'h0 : ((pend && pa == xa) ? pd : mem_m[xa]);
    e_err  = (r || w) && !xin;
    e_drop = ww && (pend || !win);
    if (w && xin) mem_m[xa] = xd;
    if (pend) begin
      if (!w) begin mem_m[pa] = pd; pend = 0; end
    end else if (ww && win) begin
      if (w) begin pend = 1; pa = wa; pd = wd; end
      else mem_m[wa] = wd;
    end
    e_busy = pend;
  endfunction

  task automatic step(input bit r, input bit w, input int xa, input logic [15:0] xd,
                      input bit ww, input int wa, input logic [15:0] wd);
    xa_rd_s = r; xa_wr_s = w; xa_addr = 16'(xa); xa_data_wr = xd;
    wa_wr_s = ww; wa_addr = 16'(wa); wa_data_wr = wd;
    model(r, w, xa, xd, ww, wa, wd);
    @(posedge clk); #1;
    xa_rd_s = 1'b0; xa_wr_s = 1'b0; wa_wr_s = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    xa_rd_s = 1'($urandom); xa_wr_s = 1'($urandom); wa_wr_s = 1'($urandom);
    xa_addr = 16'($urandom_range(0, 7)); wa_addr = 16'($urandom_range(0, 7));
    xa_data_wr = 16'($urandom); wa_data_wr = 16'($urandom);
    @(posedge clk); #1;
    rst_n = 1'b1; xa_rd_s = 1'b0; xa_wr_s = 1'b0; wa_wr_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    pend = 0; e_rd = '0; e_vld = 0; e_err = 0; e_drop = 0; e_busy = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({xa_data_rd, xa_rd_valid, xa_err, wa_drop, wa_busy} !== 20'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got rd=%h vld=%b err=%b drop=%b busy=%b, want all 0",
               xa_data_rd, xa_rd_valid, xa_err, wa_drop, wa_busy);
    end
    step(1, 0, 5, 0, 0, 0, 0);
    n_cmp++;
    if (xa_rd_valid !== 1'b1 || xa_data_rd !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_read5: got vld=%b rd=%h, want vld=1 rd=0000", xa_rd_valid, xa_data_rd);
    end
  endtask

  task automatic test_rw();
    step(0, 1, 3, 16'h1234, 0, 0, 0);
    step(1, 0, 3, 0, 0, 0, 0);
    n_cmp++;
    if (xa_data_rd !== 16'h1234 || xa_rd_valid !== 1'b1 || xa_err !== 1'b0) begin
      n_bad++;
      $display("FAIL rw_addr3: got rd=%h vld=%b err=%b, want 1234/1/0", xa_data_rd, xa_rd_valid, xa_err);
    end
    step(1, 1, 3, 16'h9999, 0, 0, 0);
    n_cmp++;
    if (xa_data_rd !== 16'h1234) begin
      n_bad++;
      $display("FAIL rd_before_wr: got %h, want 1234", xa_data_rd);
    end
  endtask

  task automatic test_collision();
    step(0, 1, 7, 16'hAAAA, 1, 7, 16'h5555);
    n_cmp++;
    if (wa_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL coll_busy: got %b, want 1", wa_busy);
    end
    step(1, 0, 7, 0, 0, 0, 0);
    n_cmp++;
    if (xa_data_rd !== 16'h5555 || wa_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL coll_fwd: got rd=%h busy=%b, want 5555/0", xa_data_rd, wa_busy);
    end
    step(1, 0, 7, 0, 0, 0, 0);
    n_cmp++;
    if (xa_data_rd !== 16'h5555) begin
      n_bad++;
      $display("FAIL coll_final: got %h, want 5555", xa_data_rd);
    end
  endtask

  task automatic test_drop();
    step(0, 1, 10, 16'h1111, 1, 11, 16'h2222);
    step(0, 1, 12, 16'h3333, 1, 11, 16'hBEEF);
    n_cmp++;
    if (wa_drop !== 1'b1 || wa_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL hold_drop: got drop=%b busy=%b, want 1/1", wa_drop, wa_busy);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (wa_drop !== 1'b0 || wa_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_release: got drop=%b busy=%b, want 0/0", wa_drop, wa_busy);
    end
    step(1, 0, 11, 0, 0, 0, 0);
    n_cmp++;
    if (xa_data_rd !== 16'h2222) begin
      n_bad++;
      $display("FAIL drop_not_stored: got %h, want 2222", xa_data_rd);
    end
    step(1, 0, 12, 0, 0, 0, 0);
    n_cmp++;
    if (xa_data_rd !== 16'h3333) begin
      n_bad++;
      $display("FAIL hold_xa_write: got %h, want 3333", xa_data_rd);
    end
  endtask

  task automatic test_oor();
    step(0, 1, 0, 16'hC0DE, 0, 0, 0);
    step(1, 1, DEPTH, 16'hFFFF, 0, 0, 0);
    n_cmp++;
    if (xa_err !== 1'b1 || xa_rd_valid !== 1'b1 || xa_data_rd !== 16'h0) begin
      n_bad++;
      $display("FAIL oor_xa: got err=%b vld=%b rd=%h, want 1/1/0000", xa_err, xa_rd_valid, xa_data_rd);
    end
    step(0, 0, 0, 0, 1, DEPTH, 16'h7777);
    n_cmp++;
    if (wa_drop !== 1'b1 || wa_busy !== 1'b0 || xa_err !== 1'b0) begin
      n_bad++;
      $display("FAIL oor_wa: got drop=%b busy=%b err=%b, want 1/0/0", wa_drop, wa_busy, xa_err);
    end
    step(1, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (xa_data_rd !== 16'hC0DE || xa_err !== 1'b0) begin
      n_bad++;
      $display("FAIL oor_alias: got rd=%h err=%b, want C0DE/0", xa_data_rd, xa_err);
    end
  endtask

  task automatic test_reset_hold();
    step(0, 1, 20, 16'h0101, 1, 21, 16'h4321);
    do_reset();
    step(1, 0, 21, 0, 0, 0, 0);
    n_cmp++;
    if (xa_data_rd !== 16'h0000 || wa_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_hold: got rd=%h busy=%b, want 0000/0", xa_data_rd, wa_busy);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 2000; c++) begin
      int xa, wa;
      xa = ($urandom_range(0, 9) == 0) ? $urandom_range(0, DEPTH + 3) : $urandom_range(0, 7);
      wa = ($urandom_range(0, 9) == 0) ? $urandom_range(0, DEPTH + 3) : $urandom_range(0, 7);
      if ($urandom_range(0, 199) == 0) do_reset();
      else step(1'($urandom), 1'($urandom), xa, 16'($urandom), 1'($urandom), wa, 16'($urandom));
      n_cmp++;
      if (xa_data_rd !== e_rd || xa_rd_valid !== e_vld || xa_err !== e_err ||
          wa_drop !== e_drop || wa_busy !== e_busy) begin
        n_bad++;
        $display("FAIL random_c%0d: got rd=%h vld=%b err=%b drop=%b busy=%b, want %h/%b/%b/%b/%b",
                 c, xa_data_rd, xa_rd_valid, xa_err, wa_drop, wa_busy, e_rd, e_vld, e_err, e_drop, e_busy);
      end
    end
    for (int a = 0; a < DEPTH; a++) begin
      step(1, 0, a, 0, 0, 0, 0);
      n_cmp++;
      if (xa_data_rd !== e_rd) begin
        n_bad++;
        $display("FAIL sweep_a%0d: got %h, want %h", a, xa_data_rd, e_rd);
      end
    end
  endtask

`ifdef SIF_PARITY_EN
  task automatic test_parity();
    xa_par_inj = 1'b1;
    step(0, 1, 2, 16'h0001, 0, 0, 0);
    xa_par_inj = 1'b0;
    step(1, 0, 2, 0, 0, 0, 0);
    n_cmp++;
    if (xa_par_err !== 1'b1 || xa_data_rd !== 16'h0001) begin
      n_bad++;
      $display("FAIL par_inj: got perr=%b rd=%h, want 1/0001", xa_par_err, xa_data_rd);
    end
    step(0, 0, 0, 0, 1, 2, 16'h0001);
    step(1, 0, 2, 0, 0, 0, 0);
    n_cmp++;
    if (xa_par_err !== 1'b0) begin
      n_bad++;
      $display("FAIL par_fixed: got perr=%b, want 0", xa_par_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rw();
    test_collision();
    test_drop();
    test_oor();
    test_reset_hold();
`ifdef SIF_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
